// File: rtl/sensor_conditioner.sv
// Conditions raw PIR, LDR, temperature and keypad inputs into clean level signals.
// Define LOCKOUT_EN to add a consecutive-fail counter and a timed keypad lockout.
module sensor_conditioner #(
    parameter int          ADC_W         = 10,
    parameter int          DEBOUNCE_CYC  = 16,
    parameter int          PIR_HOLD_CYC  = 1000,
    parameter int          DARK_ON       = 300,
    parameter int          DARK_OFF      = 350,
    parameter int          TEMP_ON       = 600,
    parameter int          TEMP_OFF      = 560,
    parameter logic [15:0] AUTH_CODE     = 16'h1234,
    parameter int          ENTRY_TMO_CYC = 5000,
    parameter int          AUTH_HOLD_CYC = 10000,
    parameter int          LOCKOUT_CYC   = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pirRaw,
    input  logic             ldrValid,
    input  logic [ADC_W-1:0] ldrLevel,
    input  logic             tempValid,
    input  logic [ADC_W-1:0] tempLevel,
    input  logic             keyValid,
    input  logic [3:0]       keyDigit,
    output logic             pir,
    output logic             isDark,
    output logic             tempHigh,
    output logic             authorized,
    output logic             authFail,
    output logic [2:0]       auth_state
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] D1      = 3'd1;
    localparam logic [2:0] D2      = 3'd2;
    localparam logic [2:0] D3      = 3'd3;
    localparam logic [2:0] GRANTED = 3'd4;
`ifdef LOCKOUT_EN
    localparam logic [2:0] LOCKOUT = 3'd5;
`endif

    localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int HOLD_W = $clog2(PIR_HOLD_CYC + 1);
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] PIR_LOAD = HOLD_W'(PIR_HOLD_CYC);

    localparam logic [ADC_W-1:0] DARK_ON_V  = ADC_W'(DARK_ON);
    localparam logic [ADC_W-1:0] DARK_OFF_V = ADC_W'(DARK_OFF);
    localparam logic [ADC_W-1:0] TEMP_ON_V  = ADC_W'(TEMP_ON);
    localparam logic [ADC_W-1:0] TEMP_OFF_V = ADC_W'(TEMP_OFF);

    // One timer serves entry timeout, grant hold and lockout; the states never overlap.
    localparam int TMR_MAX = (AUTH_HOLD_CYC > ENTRY_TMO_CYC)
        ? ((AUTH_HOLD_CYC > LOCKOUT_CYC) ? AUTH_HOLD_CYC : LOCKOUT_CYC)
        : ((ENTRY_TMO_CYC > LOCKOUT_CYC) ? ENTRY_TMO_CYC : LOCKOUT_CYC);
    localparam int TMR_W = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(ENTRY_TMO_CYC - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(AUTH_HOLD_CYC);
`ifdef LOCKOUT_EN
    localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCKOUT_CYC);
`endif

    logic              sync1, sync2, pir_stable, pir_accept;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    logic [2:0]        state;
    logic [11:0]       code;
    logic [TMR_W-1:0]  timer;
    logic              digit_ok;
`ifdef LOCKOUT_EN
    logic [1:0]        fails;
`endif

    assign pir_accept = (sync2 != pir_stable) && (db_cnt == DB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            pir_stable <= 1'b0;
            db_cnt     <= '0;
            hold_cnt   <= '0;
        end else begin
            sync1 <= pirRaw;
            sync2 <= sync1;
            if (sync2 == pir_stable) begin
                db_cnt <= '0;
            end else if (pir_accept) begin
                db_cnt     <= '0;
                pir_stable <= sync2;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            if (pir_accept && !sync2) begin
                hold_cnt <= PIR_LOAD;
            end else if (pir_accept && sync2) begin
                hold_cnt <= '0;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

    assign pir = pir_stable | (hold_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            isDark   <= 1'b0;
            tempHigh <= 1'b0;
        end else begin
            if (ldrValid) begin
                if (!isDark && ldrLevel < DARK_ON_V) isDark <= 1'b1;
                else if (isDark && ldrLevel > DARK_OFF_V) isDark <= 1'b0;
            end
            if (tempValid) begin
                if (tempLevel >= TEMP_ON_V) tempHigh <= 1'b1;
                else if (tempLevel <= TEMP_OFF_V) tempHigh <= 1'b0;
            end
        end
    end

    assign digit_ok = keyValid && (keyDigit != 4'hF);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            code     <= '0;
            timer    <= '0;
            authFail <= 1'b0;
`ifdef LOCKOUT_EN
            fails    <= '0;
`endif
        end else begin
            authFail <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (digit_ok) begin
                        code  <= {code[7:0], keyDigit};
                        state <= D1;
                    end
                end
                D1, D2, D3: begin
                    if (keyValid) begin
                        timer <= '0;
                        if (keyDigit == 4'hF) begin
                            state <= IDLE;
                        end else if (state != D3) begin
                            code  <= {code[7:0], keyDigit};
                            state <= state + 3'd1;
                        end else if ({code, keyDigit} == AUTH_CODE) begin
                            state <= GRANTED;
                            timer <= HOLD_LOAD;
`ifdef LOCKOUT_EN
                            fails <= '0;
`endif
                        end else begin
                            authFail <= 1'b1;
`ifdef LOCKOUT_EN
                            if (fails == 2'd2) begin
                                state <= LOCKOUT;
                                timer <= LOCK_LOAD;
                                fails <= '0;
                            end else begin
                                state <= IDLE;
                                fails <= fails + 2'd1;
                            end
`else
                            state <= IDLE;
`endif
                        end
                    end else if (timer == TMO_LAST) begin
                        state <= IDLE;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                GRANTED: begin
                    // The cycle the hold count would reach zero is the first one with authorized low.
                    if ((keyValid && keyDigit == 4'hF) || timer <= TMR_W'(1)) begin
                        state <= IDLE;
                        timer <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
`ifdef LOCKOUT_EN
                LOCKOUT: begin
                    if (timer <= TMR_W'(1)) begin
                        state <= IDLE;
                        timer <= '0;
                        fails <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    assign authorized = (state == GRANTED);
    assign auth_state = state;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed and randomized bench for sensor_conditioner, with a cycle-level reference
// model of the sensor paths and directed keypad sequences (lockout steps under LOCKOUT_EN).
module tb_sensor_conditioner;

    localparam int DB       = 4;
    localparam int PIR_HOLD = 20;

    logic       clk, rst;
    logic       pirRaw, ldrValid, tempValid, keyValid;
    logic [9:0] ldrLevel, tempLevel;
    logic [3:0] keyDigit;
    logic       pir, isDark, tempHigh, authorized, authFail;
    logic [2:0] auth_state;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    bit pir_hist[$];
    bit m_stable, m_fell, m_dark, m_hot;
    int cyc_n = 0;
    int m_fall_at = 0;

    sensor_conditioner #(
        .DEBOUNCE_CYC (DB),
        .PIR_HOLD_CYC (PIR_HOLD),
        .ENTRY_TMO_CYC(50),
        .AUTH_HOLD_CYC(100),
        .LOCKOUT_CYC  (200)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pirRaw    (pirRaw),
        .ldrValid  (ldrValid),
        .ldrLevel  (ldrLevel),
        .tempValid (tempValid),
        .tempLevel (tempLevel),
        .keyValid  (keyValid),
        .keyDigit  (keyDigit),
        .pir       (pir),
        .isDark    (isDark),
        .tempHigh  (tempHigh),
        .authorized(authorized),
        .authFail  (authFail),
        .auth_state(auth_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Applies the rules to the inputs the DUT sees at the coming clock edge.
    task automatic model_edge();
        bit all_eq;
        cyc_n++;
        if (rst) begin
            pir_hist.delete();
            for (int i = 0; i < DB + 2; i++) pir_hist.push_back(1'b0);
            m_stable = 1'b0;
            m_fell   = 1'b0;
            m_dark   = 1'b0;
            m_hot    = 1'b0;
            return;
        end
        pir_hist.push_front(pirRaw);
        void'(pir_hist.pop_back());
        // pir_hist[2] is the raw value two edges back, i.e. what leaves the synchroniser now.
        all_eq = 1'b1;
        for (int i = 2; i < DB + 2; i++) if (pir_hist[i] != pir_hist[2]) all_eq = 1'b0;
        if (all_eq && pir_hist[2] != m_stable) begin
            m_stable = pir_hist[2];
            if (!m_stable) begin
                m_fell    = 1'b1;
                m_fall_at = cyc_n;
            end
        end
        if (ldrValid) begin
            if (!m_dark && ldrLevel < 10'd300) m_dark = 1'b1;
            else if (m_dark && ldrLevel > 10'd350) m_dark = 1'b0;
        end
        if (tempValid) begin
            if (tempLevel >= 10'd600) m_hot = 1'b1;
            else if (tempLevel <= 10'd560) m_hot = 1'b0;
        end
    endtask

    function automatic logic model_pir();
        return m_stable || (m_fell && (cyc_n - m_fall_at) < PIR_HOLD);
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check("pir_model", pir, model_pir());
        check("dark_model", isDark, m_dark);
        check("temp_model", tempHigh, m_hot);
    endtask

    task automatic press(input logic [3:0] d);
        keyValid = 1'b1;
        keyDigit = d;
        step();
        keyValid = 1'b0;
        keyDigit = 4'h0;
    endtask

    task automatic press_code(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
    endtask

    int   ldr_v[5]  = '{400, 299, 320, 350, 351};
    logic ldr_e[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int   temp_v[4] = '{599, 600, 561, 560};
    logic temp_e[4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        logic [15:0] bad;
        rst = 1'b1; pirRaw = 1'b0; ldrValid = 1'b0; tempValid = 1'b0; keyValid = 1'b0;
        ldrLevel = '0; tempLevel = '0; keyDigit = '0;
        @(negedge clk);
        step();
        step();
        check("rst_pir", pir, 1'b0);
        check("rst_dark", isDark, 1'b0);
        check("rst_temp", tempHigh, 1'b0);
        check("rst_auth", authorized, 1'b0);
        check("rst_fail", authFail, 1'b0);
        check("rst_state_known", (^auth_state) !== 1'bx, 1'b1);
        rst = 1'b0;
        step();

        // Short PIR pulse is rejected; a long one appears after 6 edges and holds 20 after release.
        pirRaw = 1'b1;
        repeat (3) step();
        pirRaw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            check("pir_glitch", pir, 1'b0);
        end
        pirRaw = 1'b1;
        repeat (5) step();
        check("pir_rise_early", pir, 1'b0);
        step();
        check("pir_rise", pir, 1'b1);
        repeat (4) step();
        pirRaw = 1'b0;
        repeat (6) step();
        check("pir_hold_start", pir, 1'b1);
        repeat (19) step();
        check("pir_hold_last", pir, 1'b1);
        step();
        check("pir_release", pir, 1'b0);

        // Hysteresis tables; levels that would flip the flag are parked between strobes.
        for (int i = 0; i < 5; i++) begin
            ldrValid = 1'b1;
            ldrLevel = 10'(ldr_v[i]);
            step();
            ldrValid = 1'b0;
            check("dark_dir", isDark, ldr_e[i]);
            ldrLevel = ldr_e[i] ? 10'd1000 : 10'd0;
            step();
            check("dark_no_strobe", isDark, ldr_e[i]);
        end
        for (int i = 0; i < 4; i++) begin
            tempValid = 1'b1;
            tempLevel = 10'(temp_v[i]);
            step();
            tempValid = 1'b0;
            check("temp_dir", tempHigh, temp_e[i]);
            tempLevel = temp_e[i] ? 10'd0 : 10'd1023;
            step();
            check("temp_no_strobe", tempHigh, temp_e[i]);
        end

        // Correct code, then the grant expires after 100 cycles.
        press(4'hF);
        check("idle_f_ignored", authorized, 1'b0);
        press(4'h1); press(4'h2); press(4'h3);
        check("auth_before_last", authorized, 1'b0);
        press(4'h4);
        check("auth_grant", authorized, 1'b1);
        check("auth_grant_nofail", authFail, 1'b0);
        repeat (99) step();
        check("auth_hold_last", authorized, 1'b1);
        step();
        check("auth_expire", authorized, 1'b0);

        press_code(16'h1234);
        repeat (10) step();
        press(4'h7);
        check("grant_ignores_digit", authorized, 1'b1);
        press(4'hF);
        check("grant_lock_cmd", authorized, 1'b0);

        press_code(16'h1235);
        check("wrong_fail", authFail, 1'b1);
        check("wrong_no_auth", authorized, 1'b0);
        step();
        check("wrong_fail_pulse", authFail, 1'b0);

        press(4'h1); press(4'h2);
        repeat (60) step();
        press(4'h3); press(4'h4);
        check("timeout_no_auth", authorized, 1'b0);
        check("timeout_no_fail", authFail, 1'b0);
        press(4'hF);

        press(4'h1); press(4'h2); press(4'h3);
        repeat (45) step();
        press(4'h4);
        check("slow_entry_grant", authorized, 1'b1);
        press(4'hF);

        press(4'h1); press(4'h2); press(4'hF);
        press_code(16'h1234);
        check("abandon_then_grant", authorized, 1'b1);
        press(4'hF);

        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 4; i++) bad[i*4 +: 4] = 4'($urandom_range(0, 14));
            if (bad == 16'h1234) bad[3:0] = 4'h5;
            press_code(bad);
            check("rand_wrong_fail", authFail, 1'b1);
            check("rand_wrong_no_auth", authorized, 1'b0);
            step();
            check("rand_wrong_pulse", authFail, 1'b0);
            press_code(16'h1234);
            check("rand_then_grant", authorized, 1'b1);
            press(4'hF);
        end

`ifdef LOCKOUT_EN
        for (int n = 0; n < 3; n++) begin
            press_code(16'h4321);
            check("lock_fail_pulse", authFail, 1'b1);
            step();
        end
        press_code(16'h1234);
        check("lock_ignores_code", authorized, 1'b0);
        check("lock_no_fail", authFail, 1'b0);
        repeat (250) step();
        press_code(16'h1234);
        check("after_lock_grant", authorized, 1'b1);
        press(4'hF);
`endif

        // Random sensor traffic, including same-cycle strobes.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) pirRaw = ~pirRaw;
            ldrValid  = ($urandom_range(0, 2) == 0);
            ldrLevel  = 10'($urandom_range(250, 400));
            tempValid = ($urandom_range(0, 2) == 0);
            tempLevel = 10'($urandom_range(540, 620));
            step();
            check("rand_no_auth", authorized, 1'b0);
        end
        pirRaw = 1'b0; ldrValid = 1'b0; tempValid = 1'b0;
        repeat (30) step();

        // Reset while granted, dark, hot and in PIR hold.
        ldrValid = 1'b1; ldrLevel = 10'd100; tempValid = 1'b1; tempLevel = 10'd700;
        step();
        ldrValid = 1'b0; tempValid = 1'b0;
        press_code(16'h1234);
        pirRaw = 1'b1;
        repeat (10) step();
        pirRaw = 1'b0;
        repeat (8) step();
        check("pre_rst_pir", pir, 1'b1);
        check("pre_rst_auth", authorized, 1'b1);
        check("pre_rst_dark", isDark, 1'b1);
        check("pre_rst_temp", tempHigh, 1'b1);
        rst = 1'b1;
        step();
        check("mid_rst_pir", pir, 1'b0);
        check("mid_rst_auth", authorized, 1'b0);
        check("mid_rst_dark", isDark, 1'b0);
        check("mid_rst_temp", tempHigh, 1'b0);
        check("mid_rst_fail", authFail, 1'b0);
        rst = 1'b0;
        repeat (5) step();
        check("post_rst_pir", pir, 1'b0);
        check("post_rst_auth", authorized, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
